// File: rtl/morse_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : morse_uart_pkg
//  Purpose : Shared definitions for the Morse-to-UART transmit path: the
//            transmitter state encoding, the frame length in bits and the
//            line idle level.
//  Config  : MORSE_UART_PARITY_EN adds the PARITY state (8E1, 11-bit frame);
//            without it frames are 8N1, 10 bits.
//  Revision: 1.0 - initial release
// ============================================================================
package morse_uart_pkg;

`ifdef MORSE_UART_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int FRAME_BITS = 11;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam int FRAME_BITS = 10;
`endif

    // UART line level when no frame is on the wire (mark).
    localparam logic c_IDLE_LEVEL = 1'b1;

endpackage
`default_nettype wire

// File: rtl/byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : byte_fifo
//  Purpose : Small synchronous byte FIFO (circular buffer, separate count).
//            Read data is the current head (first-word fall-through), so a
//            consumer captures dout on the same edge it asserts pop.
//  Ports   : clk, reset (sync, active high)
//            push/din  - write request and data
//            pop/dout  - read request and head data
//            count     - entries held, 0..2^FIFO_AW
//            full, empty
//            drop      - push rejected this cycle (full and no pop)
//  Revision: 1.0 - initial release
// ============================================================================
module byte_fifo #(
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [7:0]         din,
    input  logic               pop,
    output logic [7:0]         dout,
    output logic [FIFO_AW:0]   count,
    output logic               full,
    output logic               empty,
    output logic               drop
);

    localparam int               c_DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] c_FULL  = (FIFO_AW + 1)'(c_DEPTH);

    logic [7:0]         r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full  = (r_count == c_FULL);
    assign empty = (r_count == '0);
    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;

    // A pop in the same cycle frees the slot the push needs; when full the
    // write pointer equals the read pointer, and the head is read before it
    // is overwritten because both happen on the same edge.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign drop      = push & full & ~w_do_pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule
`default_nettype wire

// File: rtl/morse_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module  : morse_uart_tx
//  Purpose : Captures each character finished by the Morse decoder (rising
//            edge of done), buffers it in byte_fifo and serialises it onto a
//            UART TX line, LSB first.
//  Ports   : clk, reset (sync, active high)
//            letter[7:0] - ASCII code from the decoder
//            done        - decoder done level; captured on 0->1
//            tx          - UART serial output, idles high
//            busy        - a frame is on the wire
//            fifo_count  - characters buffered, not yet popped
//            overflow    - sticky: a character was dropped (FIFO full)
//  Config  : MORSE_UART_PARITY_EN adds an even parity bit (8E1); default 8N1.
//  Revision: 1.0 - initial release
// ============================================================================
module morse_uart_tx #(
    parameter int CLKS_PER_BIT = 1085,
    parameter int FIFO_AW      = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         letter,
    input  logic               done,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);
    import morse_uart_pkg::*;

    localparam int                  c_BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);

    // Bit counter tracks frame position: 0 = start, 1..8 = data bits.
`ifdef MORSE_UART_PARITY_EN
    localparam logic [3:0] c_LAST_DATA_POS = 4'(FRAME_BITS - 3);
`else
    localparam logic [3:0] c_LAST_DATA_POS = 4'(FRAME_BITS - 2);
`endif

    logic                r_done_q;
    logic                w_push;
    logic                w_pop;
    logic [7:0]          w_fifo_dout;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_fifo_drop;
    logic [FIFO_AW:0]    w_fifo_count;
    logic                w_unused_full;
    logic                r_overflow;

    tx_state_t           r_state;
    tx_state_t           w_state_nxt;
    logic [7:0]          r_shift;
    logic [7:0]          w_shift_nxt;
    logic [3:0]          r_bit_cnt;
    logic [3:0]          w_bit_cnt_nxt;
    logic [c_BAUD_W-1:0] r_baud_cnt;
    logic [c_BAUD_W-1:0] w_baud_cnt_nxt;
    logic                w_bit_end;
    logic                w_tx;
`ifdef MORSE_UART_PARITY_EN
    logic                r_parity;
    logic                w_parity_nxt;
`endif

    // ---------------------------------------------------------------- capture
    // done is a level; only its rising edge counts as a new character.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_done_q <= 1'b0;
        end else begin
            r_done_q <= done;
        end
    end

    assign w_push = done & ~r_done_q;

    byte_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (letter),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .count (w_fifo_count),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .drop  (w_fifo_drop)
    );

    // Full is folded into drop inside the FIFO; nothing else needs it here.
    assign w_unused_full = w_fifo_full;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_fifo_drop) begin
            r_overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------ transmitter
    assign w_bit_end = (r_baud_cnt == c_BAUD_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_baud_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_baud_cnt <= w_baud_cnt_nxt;
        end
    end

`ifdef MORSE_UART_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_baud_cnt_nxt = w_bit_end ? '0 : r_baud_cnt + 1'b1;
        w_pop          = 1'b0;
        w_tx           = c_IDLE_LEVEL;
`ifdef MORSE_UART_PARITY_EN
        w_parity_nxt   = r_parity;
`endif

        case (r_state)
            ST_IDLE: begin
                w_baud_cnt_nxt = '0;
                if (!w_fifo_empty) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = w_fifo_dout;
                    w_bit_cnt_nxt = '0;
`ifdef MORSE_UART_PARITY_EN
                    w_parity_nxt  = ^w_fifo_dout;
`endif
                    w_state_nxt   = ST_START;
                end
            end

            ST_START: begin
                w_tx = 1'b0;
                if (w_bit_end) begin
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    w_state_nxt   = ST_DATA;
                end
            end

            ST_DATA: begin
                w_tx = r_shift[0];
                if (w_bit_end) begin
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    if (r_bit_cnt == c_LAST_DATA_POS) begin
`ifdef MORSE_UART_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end

`ifdef MORSE_UART_PARITY_EN
            ST_PARITY: begin
                w_tx = r_parity;
                if (w_bit_end) begin
                    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    w_state_nxt   = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                w_tx = 1'b1;
                if (w_bit_end) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign tx         = w_tx;
    assign busy       = (r_state != ST_IDLE);
    assign fifo_count = w_fifo_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_morse_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module  : tb_morse_uart_tx
//  Purpose : Self-checking bench for morse_uart_tx with CLKS_PER_BIT = 4.
//            A line monitor reassembles frames from tx; directed vectors and
//            hand-written sequences compare them against expected frames.
//  Config  : define MORSE_UART_PARITY_EN to exercise the 8E1 build.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_morse_uart_tx;

    localparam int CPB = 4;
`ifdef MORSE_UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] letter;
    logic       done;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;
    logic       overflow;

    morse_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .letter     (letter),
        .done       (done),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------------------------------------------------- line monitor
    // Frame bit b occupies samples b*CPB .. b*CPB+CPB-1 after the first low
    // sample; every sample of a bit must agree and busy must stay high.
    logic [10:0] rx_frame_q [$];
    int          rx_start_q [$];
    bit          rx_ok_q    [$];
    logic [10:0] m_fr;
    bit          m_ok;
    bit          m_ab;
    int          m_st;

    initial begin
        forever begin
            @(negedge clk); #1;
            if (tx === 1'b0 && reset === 1'b0) begin
                m_fr = '0; m_ok = 1'b1; m_ab = 1'b0; m_st = cyc;
                for (int b = 0; b < FB; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (!(b == 0 && c == 0)) begin
                            @(negedge clk); #1;
                        end
                        if (reset === 1'b1) m_ab = 1'b1;
                        if (c == 0) m_fr[b] = tx;
                        else if (tx !== m_fr[b]) m_ok = 1'b0;
                        if (busy !== 1'b1) m_ok = 1'b0;
                    end
                end
                if (!m_ab) begin
                    rx_frame_q.push_back(m_fr);
                    rx_start_q.push_back(m_st);
                    rx_ok_q.push_back(m_ok);
                end
            end
        end
    end

    task automatic clear_rx();
        rx_frame_q.delete();
        rx_start_q.delete();
        rx_ok_q.delete();
    endtask

    function automatic logic [10:0] frame_at(input int i);
        return (rx_frame_q.size() > i) ? rx_frame_q[i] : 11'h7FF;
    endfunction

    function automatic int start_at(input int i);
        return (rx_start_q.size() > i) ? rx_start_q[i] : -1000;
    endfunction

    function automatic bit ok_at(input int i);
        return (rx_ok_q.size() > i) ? rx_ok_q[i] : 1'b0;
    endfunction

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (rx_frame_q.size() < n && t < budget) begin
            tick(1);
            t++;
        end
        check($sformatf("frame_wait_%0d", n), 32'(rx_frame_q.size() >= n), 32'd1);
    endtask

    task automatic pulse(input logic [7:0] l);
        letter = l;
        done   = 1'b1;
        tick(1);
        done   = 1'b0;
        tick(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    // Expected frame as sent on the wire, bit 0 first: start, data LSB..MSB,
    // [parity], stop.  par is the hand-computed even parity of the byte.
    function automatic logic [10:0] exp_frame(input logic [7:0] l, input logic [10:0] par_frame);
`ifdef MORSE_UART_PARITY_EN
        return par_frame;
`else
        return {2'b01, l, 1'b0};
`endif
    endfunction

    typedef struct {
        logic [7:0]  letter;
        logic [10:0] par_frame;
    } vec_t;

    vec_t vecs [6];
    int   t0;
    int   s0;
    int   peak;
    int   tw;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        // letter, {stop, parity, data, start}
        vecs[0] = '{8'h53, 11'b1_0_01010011_0};
        vecs[1] = '{8'h07, 11'b1_1_00000111_0};
        vecs[2] = '{8'h00, 11'b1_0_00000000_0};
        vecs[3] = '{8'hFF, 11'b1_0_11111111_0};
        vecs[4] = '{8'h80, 11'b1_1_10000000_0};
        vecs[5] = '{8'hA5, 11'b1_0_10100101_0};

        reset  = 1'b1;
        done   = 1'b0;
        letter = 8'h00;
        tick(3); #1;
        check("rst_tx",       32'(tx),         32'd1);
        check("rst_busy",     32'(busy),       32'd0);
        check("rst_count",    32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow),   32'd0);
        tick(1);
        reset = 1'b0;
        tick(2);

        // ---------------------------------------------- single characters
        for (int i = 0; i < 6; i++) begin
            clear_rx();
            t0     = cyc;
            letter = vecs[i].letter;
            done   = 1'b1;
            tick(1);
            done   = 1'b0;
            wait_frames(1, 100);
            check($sformatf("frame_%0h", vecs[i].letter), 32'(frame_at(0)),
                  32'(exp_frame(vecs[i].letter, vecs[i].par_frame)));
            check($sformatf("bits_stable_%0h", vecs[i].letter), 32'(ok_at(0)), 32'd1);
            check($sformatf("start_latency_%0h", vecs[i].letter), 32'(start_at(0)), 32'(t0 + 2));
            tick(4);
        end

        // -------------------------------------------------- held done
        clear_rx();
        letter = 8'h45;
        done   = 1'b1;
        peak   = 0;
        for (int i = 0; i < 200; i++) begin
            tick(1); #1;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        done = 1'b0;
        tick(60);
        check("held_frames",   32'(rx_frame_q.size()), 32'd1);
        check("held_frame",    32'(frame_at(0)), 32'(exp_frame(8'h45, 11'b1_1_01000101_0)));
        check("held_peak",     32'(peak), 32'd1);
        check("held_overflow", 32'(overflow), 32'd0);

        // ----------------------------------------------- burst / overflow
        do_reset();
        clear_rx();
        for (int i = 0; i < 6; i++) pulse(8'h41 + 8'(i));
        #1;
        check("burst_count",    32'(fifo_count), 32'd4);
        check("burst_overflow", 32'(overflow),   32'd1);
        wait_frames(5, 300);
        check("burst_c1", 32'(frame_at(0)), 32'(exp_frame(8'h41, 11'b1_0_01000001_0)));
        check("burst_c2", 32'(frame_at(1)), 32'(exp_frame(8'h42, 11'b1_0_01000010_0)));
        check("burst_c3", 32'(frame_at(2)), 32'(exp_frame(8'h43, 11'b1_1_01000011_0)));
        check("burst_c4", 32'(frame_at(3)), 32'(exp_frame(8'h44, 11'b1_0_01000100_0)));
        check("burst_c5", 32'(frame_at(4)), 32'(exp_frame(8'h45, 11'b1_1_01000101_0)));
        for (int i = 1; i < 5; i++) begin
            check($sformatf("burst_gap_%0d", i), 32'(start_at(i) - start_at(i - 1)),
                  32'(FB * CPB + 1));
        end
        tick(60);
        check("burst_frames_total", 32'(rx_frame_q.size()), 32'd5);
        check("burst_drained",      32'(fifo_count), 32'd0);
        check("burst_sticky",       32'(overflow),   32'd1);

        // ------------------------------------- full FIFO, push with pop
        do_reset();
        clear_rx();
        for (int i = 0; i < 5; i++) pulse(8'h61 + 8'(i));
        #1;
        check("full_count", 32'(fifo_count), 32'd4);
        tw = 0;
        while (busy !== 1'b0 && tw < 100) begin
            tick(1); #1;
            tw++;
        end
        check("full_idle_seen", 32'(busy), 32'd0);
        letter = 8'h66;
        done   = 1'b1;
        tick(1);
        done   = 1'b0;
        #1;
        check("full_pushpop_count",    32'(fifo_count), 32'd4);
        check("full_pushpop_overflow", 32'(overflow),   32'd0);
        wait_frames(6, 400);
        check("full_frame2", 32'(frame_at(1)), 32'(exp_frame(8'h62, 11'b1_1_01100010_0)));
        check("full_frame6", 32'(frame_at(5)), 32'(exp_frame(8'h66, 11'b1_0_01100110_0)));

        // ----------------------------------------------- reset mid-frame
        do_reset();
        clear_rx();
        t0 = cyc;
        s0 = t0 + 2;
        pulse(8'h5A);
        for (int i = 1; i < 6; i++) pulse(8'h5A + 8'(i));
        tw = 0;
        #1;
        while (cyc < s0 + 17 && tw < 100) begin
            tick(1); #1;
            tw++;
        end
        check("mid_in_data3", 32'(tx), 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        #1;
        check("mid_tx",       32'(tx),         32'd1);
        check("mid_busy",     32'(busy),       32'd0);
        check("mid_count",    32'(fifo_count), 32'd0);
        check("mid_overflow", 32'(overflow),   32'd0);
        tick(40);
        check("mid_no_frame", 32'(rx_frame_q.size()), 32'd0);
        t0     = cyc;
        letter = 8'h3C;
        done   = 1'b1;
        tick(1);
        done   = 1'b0;
        wait_frames(1, 100);
        check("post_reset_frame",  32'(frame_at(0)), 32'(exp_frame(8'h3C, 11'b1_0_00111100_0)));
        check("post_reset_stable", 32'(ok_at(0)), 32'd1);
        check("post_reset_start",  32'(start_at(0)), 32'(t0 + 2));

        tick(10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/morse_uart_tx.md
# morse_uart_tx

Downstream consumer of the Morse decoder's `letter`/`done` outputs. Each newly decoded ASCII character is captured, buffered in a small FIFO and serialised onto a UART TX line, so a host terminal sees the decoded text. The block sits between the decoder and the board's Pmod/UART pin, in parallel with the existing `je` LED display.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 1085: clock cycles per UART bit (125 MHz / 115200 baud); legal range 2..65535.
- `FIFO_AW`, default 2: FIFO address width; depth = 2^`FIFO_AW`, so 4 entries by default.

Ports:
- `clk`  input  1: system clock; all logic rises on `posedge clk`.
- `reset`  input  1: synchronous, active-high reset.
- `letter`  input  8: ASCII code from the decoder; valid when `done` is high.
- `done`  input  1: decoder done flag, treated as a level; a character is captured on its 0→1 transition.
- `tx`  output  1: UART serial output; idles high.
- `busy`  output  1: high while a frame is being shifted out (any state other than IDLE).
- `fifo_count`  output  `FIFO_AW`+1: number of characters buffered and not yet popped.
- `overflow`  output  1: sticky; set when a character is dropped because the FIFO is full.

## Operation

- Edge detect: `done_q` is `done` registered. `push = done & ~done_q`. `done` held high for many cycles yields exactly one push.
- FIFO:
  - Circular buffer with `FIFO_AW`-bit read and write pointers that wrap modulo depth.
  - The count is kept separately, range 0..depth.
  - Push when not full writes `letter` at the write pointer.
  - Push when full and no pop in the same cycle: the character is dropped and `overflow` is set to 1.
  - Push when full with a pop in the same cycle: the push is accepted and the count is unchanged.
  - Push and pop together in any other state: both happen and the count is unchanged.
- Transmitter FSM states:
  - IDLE: `tx` = 1. If `fifo_count` is not 0, pop the head into the shift register, clear the bit counter and baud counter, and go to START.
  - START: `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx` = `shift[0]`. Each bit lasts `CLKS_PER_BIT` cycles. The register shifts right, LSB first. After bit 7, go to PARITY if that feature is compiled in, otherwise to STOP.
  - PARITY: present only when compiled in (see Configuration). `tx` = even parity of the byte for `CLKS_PER_BIT` cycles, then go to STOP.
  - STOP: `tx` = 1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- Baud counter:
  - Counts 0..`CLKS_PER_BIT`-1.
  - Its width is clog2(`CLKS_PER_BIT`) bits.
  - The bit boundary is the cycle where the counter reaches `CLKS_PER_BIT`-1.
- `busy` is high in every state other than IDLE.
- `overflow` is cleared only by `reset`.

## Timing

- Reset values: `tx` = 1, `busy` = 0, `fifo_count` = 0, `overflow` = 0, FSM in IDLE, both pointers 0, `done_q` = 0.
- Reset mid-frame: `tx` returns high at the next edge. The FIFO contents are discarded and the partial frame is abandoned.
- Reset while `done` is high: `done_q` clears, so a push occurs on the first post-reset cycle in which `done` = 1.
- Latency from an empty, idle block:
  - Edge E0 samples `push` and writes the FIFO.
  - Edge E1: the FSM in IDLE pops.
  - `tx` goes low (start bit) after E1 and stays low for `CLKS_PER_BIT` cycles.
- Frame length: 10×`CLKS_PER_BIT` cycles (8N1), or 11×`CLKS_PER_BIT` with parity.
- Back-to-back frames: exactly one IDLE cycle (`tx` high) between the end of STOP and the next START.
- `fifo_count` updates on the edge after the push or pop.

## Configuration

- Macro: `MORSE_UART_PARITY_EN`.
- Defined: the PARITY state is compiled in. Frames are 8E1, 11 bits. The parity bit is the XOR of the 8 data bits.
- Undefined: the PARITY state and its logic are absent. Frames are 8N1, 10 bits. DATA goes directly to STOP.

## Structure

- Shared package `morse_uart_pkg` holds:
  - the FSM state encoding (IDLE, START, DATA, PARITY, STOP);
  - the `FRAME_BITS` constant (10, or 11 under the macro);
  - the idle level constant.
- Sub-module `byte_fifo`, parameterised by `FIFO_AW`, provides the synchronous FIFO.
  - Ports: `clk`, `reset`, `push`, `din`, `pop`, `dout`, `count`, `full`, `empty`, `drop`.
- The top level instantiates `byte_fifo` plus the edge detector and the transmitter FSM.

## Test plan

Use `CLKS_PER_BIT` = 4 for all scenarios.

- Single character: pulse `done` with `letter` = 8'h53 ('S').
  - `tx` shows start 0, then bits 1,1,0,0,1,0,1,0, then stop 1.
  - Each bit lasts 4 cycles; the start bit begins 1 cycle after the push edge.
- Held `done`: hold `done` high for 200 cycles with `letter` = 8'h45.
  - Exactly one frame is sent.
  - `fifo_count` peaks at 1.
- Burst and overflow: 6 pushes on consecutive done rising edges (8'h41..8'h46) while the first frame is in flight.
  - 8'h41 is popped immediately and 8'h42..8'h45 are buffered.
  - 8'h46 is dropped and `overflow` = 1.
  - Frames 8'h41..8'h45 are then sent in order, each separated by 1 idle cycle.
- Full with simultaneous pop: FIFO full, push on the same cycle the FSM pops from IDLE.
  - The push is accepted, `fifo_count` stays at 4, and `overflow` stays 0.
- Reset mid-frame: assert `reset` during DATA bit 3.
  - Next cycle: `tx` = 1, `busy` = 0, `fifo_count` = 0, `overflow` = 0.
  - A new push afterwards produces a clean frame.
- Parity (with `MORSE_UART_PARITY_EN` defined): send 8'h53.
  - The parity bit is 0 (four ones) and the frame is 44 cycles.
  - For 8'h07 the parity bit is 1.
